// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: two-stage pipelined bitwise logic unit with a result
// accumulator and valid/ready handshakes on both sides.
// Stage p0 holds the accepted command; stage p1 is the output register
// holding the result, its flags and the accumulator copy.
module logic_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Op,
  input  logic             UseAcc,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Sign,
  output logic             Parity
);

  // Bitwise operation selected by op; all results are pure WIDTH-bit logic.
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a | b);
      3'd3:    r = ~(a & b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = b;
    endcase
    return r;
  endfunction

  // Status flags of a result: {zero, sign, parity}.
  function automatic logic [2:0] flags_of(input logic [WIDTH-1:0] r);
    return {(r == '0), r[WIDTH-1], ^r};
  endfunction

  logic             vld_p0;
  logic [2:0]       op_p0;
  logic             use_acc_p0;
  logic [WIDTH-1:0] in1_p0;
  logic [WIDTH-1:0] in2_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] out_p1;
  logic             zero_p1;
  logic             sign_p1;
  logic             parity_p1;
  logic [WIDTH-1:0] acc_p1;

  logic             accept;
  logic             advance;
  logic             consume;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  // Handshake control: S1 can refill on the same edge it drains.
  always_comb begin
    InReady = !vld_p0 || !vld_p1 || OutReady;
    accept  = InValid && InReady;
    advance = vld_p0 && (!vld_p1 || OutReady);
    consume = vld_p1 && OutReady;
    opa     = use_acc_p0 ? acc_p1 : in1_p0;
    result  = logic_op(op_p0, opa, in2_p0);
    flags   = flags_of(result);
  end

  // ---- stage p0: command capture ----
  // Valid bit for S1: set on accept, cleared when its command advances.
  always_ff @(posedge Clk) begin
    if (Reset)        vld_p0 <= 1'b0;
    else if (accept)  vld_p0 <= 1'b1;
    else if (advance) vld_p0 <= 1'b0;
  end

  // S1 command fields, loaded only on accept.
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_p0      <= Op;
      use_acc_p0 <= UseAcc;
      in1_p0     <= In1;
      in2_p0     <= In2;
    end
  end

  // ---- stage p1: result, flags and accumulator ----
  // Output register and accumulator load together on advance; a consume
  // without advance only drops the valid bit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1    <= 1'b0;
      out_p1    <= '0;
      zero_p1   <= 1'b0;
      sign_p1   <= 1'b0;
      parity_p1 <= 1'b0;
      acc_p1    <= '0;
    end else if (advance) begin
      vld_p1    <= 1'b1;
      out_p1    <= result;
      zero_p1   <= flags[2];
      sign_p1   <= flags[1];
      parity_p1 <= flags[0];
      acc_p1    <= result;
    end else if (consume) begin
      vld_p1    <= 1'b0;
    end
  end

  assign OutValid = vld_p1;
  assign Out      = out_p1;
  assign Zero     = zero_p1;
  assign Sign     = sign_p1;
  assign Parity   = parity_p1;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Scoreboard bench for logic_op_sequencer: the driver pushes the expected
// result when a command is accepted; the monitor pops and checks whenever a
// result is consumed.
module tb_logic_op_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       InValid;
  logic       InReady;
  logic [2:0] Op;
  logic       UseAcc;
  logic [7:0] In1;
  logic [7:0] In2;
  logic       OutValid;
  logic       OutReady;
  logic [7:0] Out;
  logic       Zero;
  logic       Sign;
  logic       Parity;

  int total = 0;
  int bad   = 0;
  int stalls;
  logic [7:0] q[$];
  logic [7:0] held;

  logic_op_sequencer #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Op(Op), .UseAcc(UseAcc), .In1(In1), .In2(In2),
    .OutValid(OutValid), .OutReady(OutReady), .Out(Out),
    .Zero(Zero), .Sign(Sign), .Parity(Parity)
  );

  always #5 Clk = ~Clk;

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result is checked against the oldest expectation.
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h expected none", Out);
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        ck("out", Out, e);
        ck("flags", {Zero, Sign, Parity}, {(e == 8'h00), e[7], ^e});
      end
    end
  end

  // Present a command and wait (bounded) for its accept edge.
  task automatic send(input logic [2:0] op, input logic ua, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp);
    int w;
    Op = op; UseAcc = ua; In1 = a; In2 = b; InValid = 1'b1;
    w = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (InReady) break;
      w++;
    end
    if (!InReady) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got InReady=0 expected 1");
    end
    @(posedge Clk);
    q.push_back(exp);
    #1;
    stalls += w;
  endtask

  task automatic idle();
    InValid = 1'b0; Op = '0; UseAcc = 1'b0; In1 = '0; In2 = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge Clk);
    #1;
    ck("queue_empty", q.size(), 0);
  endtask

  initial begin
    idle();
    OutReady = 1'b1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    ck("rst_outvalid", OutValid, 0);
    ck("rst_out", Out, 0);
    ck("rst_flags", {Zero, Sign, Parity}, 0);
    Reset = 1'b0;

    // Basic NOR with latency check
    send(3'd2, 1'b0, 8'h0F, 8'h30, 8'hC0);
    idle();
    ck("lat_not_yet", OutValid, 0);
    @(posedge Clk); #1;
    ck("lat_valid", OutValid, 1);
    ck("lat_out", Out, 8'hC0);
    ck("lat_flags", {Zero, Sign, Parity}, 3'b010);
    // Acc readback through OR with zero
    send(3'd1, 1'b1, 8'h00, 8'h00, 8'hC0);
    idle();
    drain();

    // Stream all opcodes back to back
    stalls = 0;
    send(3'd0, 1'b0, 8'hA5, 8'h3C, 8'h24);
    send(3'd1, 1'b0, 8'hA5, 8'h3C, 8'hBD);
    send(3'd2, 1'b0, 8'hA5, 8'h3C, 8'h42);
    send(3'd3, 1'b0, 8'hA5, 8'h3C, 8'hDB);
    send(3'd4, 1'b0, 8'hA5, 8'h3C, 8'h99);
    send(3'd5, 1'b0, 8'hA5, 8'h3C, 8'h66);
    send(3'd6, 1'b0, 8'hA5, 8'h3C, 8'h5A);
    send(3'd7, 1'b0, 8'hA5, 8'h3C, 8'h3C);
    idle();
    ck("stream_stalls", stalls, 0);
    drain();

    // Accumulator chain
    stalls = 0;
    send(3'd7, 1'b0, 8'h00, 8'hFF, 8'hFF);
    send(3'd4, 1'b1, 8'h00, 8'h0F, 8'hF0);
    send(3'd0, 1'b1, 8'h00, 8'h3C, 8'h30);
    idle();
    ck("chain_stalls", stalls, 0);
    drain();

    // Backpressure
    OutReady = 1'b0;
    send(3'd7, 1'b0, 8'h00, 8'h11, 8'h11);
    send(3'd7, 1'b0, 8'h00, 8'h22, 8'h22);
    ck("bp_inready_low", InReady, 0);
    ck("bp_valid", OutValid, 1);
    held = Out;
    ck("bp_out", held, 8'h11);
    Op = 3'd4; UseAcc = 1'b1; In1 = 8'h00; In2 = 8'h0F; InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      ck("bp_stable", Out, held);
      ck("bp_hold_ready", InReady, 0);
    end
    OutReady = 1'b1;
    send(3'd4, 1'b1, 8'h00, 8'h0F, 8'h2D);
    idle();
    drain();

    // Flags
    send(3'd0, 1'b0, 8'h55, 8'hAA, 8'h00);
    send(3'd7, 1'b0, 8'h00, 8'h01, 8'h01);
    idle();
    drain();

    // Reset with both stages full
    OutReady = 1'b0;
    send(3'd7, 1'b0, 8'h00, 8'h77, 8'h77);
    send(3'd7, 1'b0, 8'h00, 8'h88, 8'h88);
    idle();
    ck("pre_rst_full", {OutValid, InReady}, 2'b10);
    Reset = 1'b1;
    @(posedge Clk); #1;
    q.delete();
    Reset = 1'b0;
    ck("mid_rst_valid", OutValid, 0);
    ck("mid_rst_out", Out, 0);
    ck("mid_rst_flags", {Zero, Sign, Parity}, 0);
    repeat (2) @(posedge Clk); #1;
    ck("mid_rst_s1_flushed", OutValid, 0);
    OutReady = 1'b1;
    send(3'd1, 1'b1, 8'hEE, 8'h12, 8'h12);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Pipelined front end for the DSP's 8-bit bitwise logic functions: AND, OR, NOR, NAND, XOR, XNOR, NOT, PASS.
- Accepts operation commands over a valid/ready handshake and computes the result.
- Presents the result with status flags over a downstream valid/ready handshake.
- Keeps an accumulator of the last result, so commands can chain on it without an external round trip.

Parameters:
- WIDTH, 8, operand/result width in bits (flag rules assume WIDTH >= 2).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  command present on Op/UseAcc/In1/In2.
- InReady  output  1  block can accept a command this cycle.
- Op  input  3  operation select (encoding below).
- UseAcc  input  1  1 = use accumulator in place of In1 as operand A.
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- OutValid  output  1  Out and the flags hold a valid result.
- OutReady  input  1  downstream accepts the result this cycle.
- Out  output  WIDTH  result.
- Zero  output  1  Out == 0.
- Sign  output  1  Out[WIDTH-1].
- Parity  output  1  XOR-reduction of Out.

Behaviour:
- Reset (synchronous, active-high) on a rising edge with Reset=1:
  - S1 valid cleared, OutValid=0, Out=0, Zero=0, Sign=0, Parity=0, accumulator Acc=0.
  - Reset dominates all handshakes.
  - A command or result in flight is discarded; a command presented in the reset cycle is not accepted.
  - InReady during reset cycle is don't-care.
- Op encoding, with A = UseAcc ? Acc : In1 and B = In2:
  - 0 AND: A&B
  - 1 OR: A|B
  - 2 NOR: ~(A|B)
  - 3 NAND: ~(A&B)
  - 4 XOR: A^B
  - 5 XNOR: ~(A^B)
  - 6 NOT: ~A
  - 7 PASS: B
- Pipeline: two register stages.
  - S1 captures Op, UseAcc, In1, In2.
  - The output register captures the computed result and flags.
- Handshakes:
  - Accept occurs when InValid & InReady at a rising edge.
  - Advance = S1valid & (!OutValid | OutReady).
  - InReady = !S1valid | (!OutValid | OutReady), combinational.
  - Out/flags/OutValid are registers only; no combinational path from In* to Out.
- Latency: command accepted at edge N gives OutValid=1 with its result after edge N+1, i.e. 2 edges with no backpressure.
- Throughput: 1 result per cycle while OutReady=1.
- Operand A resolution:
  - When UseAcc=1, A is resolved in S1 at the advance edge using the current Acc.
  - Acc is loaded with the computed result at the same edge Out is loaded.
  - Back-to-back chained commands therefore see the immediately preceding result with no bubble; no hazard stall.
- Output register:
  - When OutValid=1 and OutReady=0, Out/flags/OutValid hold stable.
  - S1 holds, and InReady=0 if S1 is occupied.
  - OutValid falls after a consume edge (OutValid & OutReady) with no advance that edge.
  - Simultaneous consume and advance loads the new result; OutValid stays 1.
- Acc is updated only on advance, never on accept or consume. Acc is not cleared when the result is consumed.
- UseAcc=0: Acc still updates with the result (Acc = last computed result, always).
- Flags are computed from the result being loaded and are registered together with Out.
- Width rule: all operations are bitwise on WIDTH bits; no carries, no extension.

Test Plan:
- Reset, then InValid=1, Op=2, In1=8'h0F, In2=8'h30, OutReady=1 → OutValid rises 2 edges after accept, Out=8'hC0, Zero=0, Sign=1, Parity=0; Acc=8'hC0.
- Stream 8 commands back-to-back (all Op codes 0..7, In1=8'hA5, In2=8'h3C), OutReady=1 → 8 consecutive OutValid cycles.
  - Results in order: 24, BD, 42, DB, 99, 66, 5A, 3C.
  - InReady never drops.
- Chain: Op=7 In2=8'hFF, then Op=4 UseAcc=1 In2=8'h0F, then Op=0 UseAcc=1 In2=8'h3C, back-to-back → Out sequence FF, F0, 30, with no stall cycles.
- Backpressure: hold OutReady=0 after first result while issuing 3 commands.
  - Out stays stable and InReady drops after the second accept.
  - Release OutReady → remaining results in order, none lost or duplicated.
- Flags: Op=0, In1=8'h55, In2=8'hAA → Out=0, Zero=1, Sign=0, Parity=0. Op=7, In2=8'h01 → Parity=1.
- Reset mid-operation: assert Reset for one edge with S1 and output both full → OutValid=0, Out=0, Acc=0 next cycle.
  - A following UseAcc=1, Op=1, In2=8'h12 command yields Out=8'h12.
